// File: rtl/sr_latch_bank.sv
// -----------------------------------------------------------------------------
// sr_latch_bank
//
// Bank of CHANNELS clocked set/reset latches with active-low set and reset
// pins. This is the synchronous replacement for the cross-coupled RS_NAND
// latch used by the locker. It sits between the key/switch inputs and the
// unlock/alarm state logic.
//
// Every channel runs the same pipeline:
//   pins -> 2-flop synchroniser -> debounce filter -> latch -> Q
// The channel also keeps a sticky flag that records entry into the
// both-asserted state. A NAND latch forbids that state; here it is resolved
// by CONFLICT_MODE.
//
// Parameters:
//   CHANNELS      number of independent channels (1..32)
//   DEBOUNCE      extra stable samples needed before a pin change is
//                 accepted (1..255)
//   CONFLICT_MODE both-asserted resolution: 0 hold, 1 set wins,
//                 2 reset wins, 3 toggle once on entry
//   RESET_Q       Q value of every channel while and after reset
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   Sn[CHANNELS]  per-channel set, active-low, asynchronous to clk
//   Rn[CHANNELS]  per-channel reset, active-low, asynchronous to clk
//   conflict_clr  per-channel synchronous clear of the conflict flag
//   Q             latch state
//   Qn            combinational complement of Q (never equal to Q)
//   conflict      sticky flag, set on entry into both-asserted
// -----------------------------------------------------------------------------
module sr_latch_bank #(
   parameter int CHANNELS      = 4,
   parameter int DEBOUNCE      = 4,
   parameter int CONFLICT_MODE = 0,
   parameter int RESET_Q       = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] Sn,
   input  logic [CHANNELS-1:0] Rn,
   input  logic [CHANNELS-1:0] conflict_clr,
   output logic [CHANNELS-1:0] Q,
   output logic [CHANNELS-1:0] Qn,
   output logic [CHANNELS-1:0] conflict
);

   localparam int              CW        = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   // Pairs are held as {Sn, Rn}. Both high is idle and both low is conflict.
   localparam logic [1:0]      PAIR_IDLE = 2'b11;
   localparam logic [1:0]      PAIR_BOTH = 2'b00;
   localparam logic            Q_INIT    = 1'(RESET_Q);

   for (genvar i = 0; i < CHANNELS; i++) begin : gChan

      logic [1:0]    r_s1;
      logic [1:0]    r_s2;
      logic [1:0]    r_cand;
      logic [CW-1:0] r_cnt;
      logic [1:0]    r_filt;
      logic [1:0]    r_fprev;
      logic          r_q;
      logic          r_conflict;

      logic          w_set;
      logic          w_rst;
      logic          w_enter;
      logic          w_qNext;

      // Two-flop synchroniser for the asynchronous pin pair. The pair is
      // captured together, so a direct set-to-reset change moves as one unit.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_s1 <= PAIR_IDLE;
            r_s2 <= PAIR_IDLE;
         end else begin
            r_s1 <= {Sn[i], Rn[i]};
            r_s2 <= r_s1;
         end
      end

      // Debounce filter. Any difference restarts the count from zero. The
      // candidate reaches filt only on the edge where the count reaches
      // DEBOUNCE, so a change must persist for DEBOUNCE+1 samples of r_s2.
      // A short pulse is dropped without ever touching filt.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cand <= PAIR_IDLE;
            r_cnt  <= CNT_MAX;
            r_filt <= PAIR_IDLE;
         end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
         end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt + CNT_ONE == CNT_MAX) begin
               r_filt <= r_cand;
            end
         end
      end

      assign w_set   = ~r_filt[1];
      assign w_rst   = ~r_filt[0];
      assign w_enter = (r_filt == PAIR_BOTH) && (r_fprev != PAIR_BOTH);

      // Next latch state from the filtered pair. Toggle mode looks at
      // w_enter, so it flips once when conflict starts and then holds for
      // as long as both inputs stay asserted.
      always_comb begin
         w_qNext = r_q;
         case ({w_set, w_rst})
            2'b10: w_qNext = 1'b1;
            2'b01: w_qNext = 1'b0;
            2'b11: begin
               if (CONFLICT_MODE == 1) begin
                  w_qNext = 1'b1;
               end else if (CONFLICT_MODE == 2) begin
                  w_qNext = 1'b0;
               end else if (CONFLICT_MODE == 3) begin
                  if (w_enter) begin
                     w_qNext = ~r_q;
                  end
               end
            end
            default: w_qNext = r_q;
         endcase
      end

      // Latch state and previous filtered pair. fprev lets the next edge
      // recognise entry into the both-asserted state.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_q     <= Q_INIT;
            r_fprev <= PAIR_IDLE;
         end else begin
            r_q     <= w_qNext;
            r_fprev <= r_filt;
         end
      end

      // Sticky conflict flag. It is set when conflict starts. If a set and a
      // clear land on the same edge, the set wins so no entry is missed.
      // Leaving the conflict state does not clear the flag.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_conflict <= 1'b0;
         end else if (w_enter) begin
            r_conflict <= 1'b1;
         end else if (conflict_clr[i]) begin
            r_conflict <= 1'b0;
         end
      end

      assign Q[i]        = r_q;
      assign Qn[i]       = ~r_q;
      assign conflict[i] = r_conflict;

   end

endmodule

// File: tb/tb_sr_latch_bank.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_bank
//
// Directed bench for sr_latch_bank. Four 4-channel banks, one per
// CONFLICT_MODE, share the same pins. A fifth 1-channel bank uses
// RESET_Q = 1. For each stimulus step, the expected Q/conflict values are
// queued with the cycle at which they must hold. A separate monitor runs on
// the falling edge, pops the entries that are due and compares them.
// -----------------------------------------------------------------------------
module tb_sr_latch_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sn  = 4'hF;
   logic [3:0] rn  = 4'hF;
   logic [3:0] clr = 4'h0;

   logic [3:0] qv  [4];
   logic [3:0] qnv [4];
   logic [3:0] cv  [4];

   logic       rqSn  = 1'b1;
   logic       rqRn  = 1'b1;
   logic       rqClr = 1'b0;
   logic       rqQ;
   logic       rqQn;
   logic       rqC;

   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      int    cyc;
      int    dut;
      int    ch;
      bit    expQ;
      bit    expC;
      string name;
   } exp_t;

   exp_t sb[$];

   // 10 ns clock. cyc counts rising edges seen so far.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One bank per conflict resolution mode, all driven by the same pins.
   for (genvar m = 0; m < 4; m++) begin : gMode
      sr_latch_bank #(
         .CHANNELS(4), .DEBOUNCE(4), .CONFLICT_MODE(m), .RESET_Q(0)
      ) dut (
         .clk(clk), .rst(rst), .Sn(sn), .Rn(rn), .conflict_clr(clr),
         .Q(qv[m]), .Qn(qnv[m]), .conflict(cv[m])
      );
   end

   // Single-channel bank with Q = 1 out of reset.
   sr_latch_bank #(
      .CHANNELS(1), .DEBOUNCE(4), .CONFLICT_MODE(0), .RESET_Q(1)
   ) dutRq (
      .clk(clk), .rst(rst), .Sn(rqSn), .Rn(rqRn), .conflict_clr(rqClr),
      .Q(rqQ), .Qn(rqQn), .conflict(rqC)
   );

   // Monitor: on each falling edge, compare every entry due on this cycle.
   // dut 4 is the RESET_Q = 1 bank.
   always @(negedge clk) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].cyc == cyc) begin
            logic aq, aqn, ac;
            if (sb[k].dut == 4) begin
               aq = rqQ; aqn = rqQn; ac = rqC;
            end else begin
               aq  = qv[sb[k].dut][sb[k].ch];
               aqn = qnv[sb[k].dut][sb[k].ch];
               ac  = cv[sb[k].dut][sb[k].ch];
            end
            checks++;
            if (aq !== sb[k].expQ || aqn !== ~sb[k].expQ || ac !== sb[k].expC) begin
               errors++;
               $display("[TB] FAIL %s: dut%0d ch%0d cycle %0d got Q=%b Qn=%b conflict=%b, expected Q=%b Qn=%b conflict=%b",
                        sb[k].name, sb[k].dut, sb[k].ch, cyc, aq, aqn, ac,
                        sb[k].expQ, ~sb[k].expQ, sb[k].expC);
            end
            sb.delete(k);
         end
      end
   end

   // Queue an expectation that must hold `delay` rising edges from now.
   task automatic checkOutput(input int dut, input int ch, input int delay,
                              input bit expQ, input bit expC, input string name);
      exp_t e;
      e.cyc  = cyc + delay;
      e.dut  = dut;
      e.ch   = ch;
      e.expQ = expQ;
      e.expC = expC;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic [3:0] s, input logic [3:0] r,
                                input logic [3:0] c);
      sn  = s;
      rn  = r;
      clr = c;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected Q on channel 2 after the first conflict entry from Q = 0:
   // hold, set wins, reset wins, toggle.
   bit modeQ1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   // Expected Q on channel 2 after the second entry. Toggle mode flips back.
   bit modeQ2 [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      $display("[TB] sr_latch_bank directed test start");
      tick(2);

      checks++;
      if (rqQ !== 1'b1 || rqQn !== 1'b0) begin
         errors++;
         $display("[TB] FAIL resetq1_direct: got Q=%b Qn=%b, expected Q=1 Qn=0", rqQ, rqQn);
      end

      // Reset state, checked while rst is still high.
      for (int c = 0; c < 4; c++) checkOutput(0, c, 1, 1'b0, 1'b0, "reset_state");
      for (int m = 1; m < 4; m++) checkOutput(m, 2, 1, 1'b0, 1'b0, "reset_state_mode");
      checkOutput(4, 0, 1, 1'b1, 1'b0, "resetq1_during_reset");
      tick(2);
      rst = 1'b0;
      checkOutput(4, 0, 3, 1'b1, 1'b0, "resetq1_after_reset");

      // Sn[0] low from cycle 0: Q[0] rises on edge 8 and not earlier.
      applyStimulus(4'b1110, 4'hF, 4'h0);
      checkOutput(0, 0, 7, 1'b0, 1'b0, "set_ch0_not_yet");
      checkOutput(0, 0, 8, 1'b1, 1'b0, "set_ch0_edge8");
      checkOutput(0, 1, 8, 1'b0, 1'b0, "set_ch0_ch1_idle");
      checkOutput(0, 2, 8, 1'b0, 1'b0, "set_ch0_ch2_idle");
      checkOutput(0, 3, 8, 1'b0, 1'b0, "set_ch0_ch3_idle");
      tick(10);
      checks++;
      if (qv[0][0] !== 1'b1 || qnv[0][0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL set_ch0_direct: got Q=%b Qn=%b, expected Q=1 Qn=0", qv[0][0], qnv[0][0]);
      end
      applyStimulus(4'hF, 4'hF, 4'h0);
      checkOutput(0, 0, 9, 1'b1, 1'b0, "ch0_holds_after_release");
      tick(10);

      // Set Q[1] first so the reset pulses can show their effect.
      applyStimulus(4'b1101, 4'hF, 4'h0);
      checkOutput(0, 1, 8, 1'b1, 1'b0, "set_ch1");
      tick(10);
      applyStimulus(4'hF, 4'hF, 4'h0);
      tick(10);

      // A 3-cycle Rn[1] pulse is too short and is filtered out.
      applyStimulus(4'hF, 4'b1101, 4'h0);
      checkOutput(0, 1, 8, 1'b1, 1'b0, "short_pulse_ignored");
      checkOutput(0, 1, 12, 1'b1, 1'b0, "short_pulse_ignored_late");
      tick(3);
      applyStimulus(4'hF, 4'hF, 4'h0);
      tick(12);

      // A 6-cycle Rn[1] pulse is accepted: Q[1] falls on edge 8.
      applyStimulus(4'hF, 4'b1101, 4'h0);
      checkOutput(0, 1, 7, 1'b1, 1'b0, "long_pulse_not_yet");
      checkOutput(0, 1, 8, 1'b0, 1'b0, "long_pulse_edge8");
      tick(6);
      applyStimulus(4'hF, 4'hF, 4'h0);
      tick(12);

      // Sn[2] and Rn[2] both low for 20 cycles, compared across all modes.
      applyStimulus(4'b1011, 4'b1011, 4'h0);
      for (int m = 0; m < 4; m++) begin
         checkOutput(m, 2, 7, 1'b0, 1'b0, "conflict_not_yet");
         checkOutput(m, 2, 8, modeQ1[m], 1'b1, "conflict_edge8");
         checkOutput(m, 2, 16, modeQ1[m], 1'b1, "conflict_held");
      end
      tick(20);
      applyStimulus(4'hF, 4'hF, 4'h0);
      for (int m = 0; m < 4; m++) checkOutput(m, 2, 10, modeQ1[m], 1'b1, "conflict_sticky");
      tick(12);

      // Pulsing conflict_clr[2] clears the flag on the next edge.
      applyStimulus(4'hF, 4'hF, 4'b0100);
      for (int m = 0; m < 4; m++) checkOutput(m, 2, 1, modeQ1[m], 1'b0, "conflict_cleared");
      tick(1);
      applyStimulus(4'hF, 4'hF, 4'h0);
      tick(3);

      // Conflict entry on the same edge as conflict_clr: the set wins.
      applyStimulus(4'b1011, 4'b1011, 4'h0);
      for (int m = 0; m < 4; m++) begin
         checkOutput(m, 2, 7, modeQ1[m], 1'b0, "reentry_not_yet");
         checkOutput(m, 2, 8, modeQ2[m], 1'b1, "set_beats_clear");
         checkOutput(m, 2, 10, modeQ2[m], 1'b1, "set_beats_clear_late");
      end
      tick(7);
      applyStimulus(4'b1011, 4'b1011, 4'b0100);
      tick(1);
      applyStimulus(4'b1011, 4'b1011, 4'h0);
      tick(4);
      applyStimulus(4'hF, 4'hF, 4'h0);
      tick(12);

      // rst arrives part-way through an Sn[3] acceptance. Outputs return to
      // reset values at once, and the pending change is discarded.
      applyStimulus(4'b0111, 4'hF, 4'h0);
      tick(5);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (qv[0][3] !== 1'b0 || qnv[0][3] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL async_reset_direct: got Q=%b Qn=%b, expected Q=0 Qn=1", qv[0][3], qnv[0][3]);
      end
      checkOutput(0, 0, 0, 1'b0, 1'b0, "async_reset_ch0");
      checkOutput(0, 3, 0, 1'b0, 1'b0, "async_reset_ch3");
      checkOutput(1, 2, 0, 1'b0, 1'b0, "async_reset_mode1_ch2");
      checkOutput(4, 0, 0, 1'b1, 1'b0, "async_reset_resetq1");
      tick(2);
      rst = 1'b0;
      checkOutput(0, 3, 7, 1'b0, 1'b0, "post_reset_ch3_not_yet");
      checkOutput(0, 3, 8, 1'b1, 1'b0, "post_reset_ch3_edge8");
      checkOutput(0, 0, 8, 1'b0, 1'b0, "post_reset_ch0_idle");
      checkOutput(4, 0, 2, 1'b1, 1'b0, "resetq1_after_second_reset");
      tick(10);
      applyStimulus(4'hF, 4'hF, 4'h0);
      tick(5);

      // Any expectation still queued was never reached.
      foreach (sb[k]) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: never checked, due cycle %0d, now cycle %0d",
                  sb[k].name, sb[k].cyc, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised bank of CHANNELS clocked set/reset latches with active-low set (Sn) and reset (Rn) inputs, matching the Exp09 locker latch convention. It is the synchronous successor to the single RS_NAND cross-coupled latch. Each channel adds:
- a two-flop synchroniser,
- a debounce filter of DEBOUNCE cycles,
- a selectable resolution for the both-asserted state, which is forbidden in a NAND latch,
- a sticky conflict flag.

The bank sits between the locker's key and switch inputs and its unlock and alarm state logic.

## Interface
- CHANNELS, 4: number of independent latch channels, 1..32.
- DEBOUNCE, 4: number of extra consecutive stable samples required before an input change is accepted, 1..255.
- CONFLICT_MODE, 0: both-asserted resolution. 0 = hold, 1 = set wins, 2 = reset wins, 3 = toggle once on entry.
- RESET_Q, 0: Q value of every channel on reset, 0 or 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Sn  in  CHANNELS  per-channel set, active-low, asynchronous to clk.
- Rn  in  CHANNELS  per-channel reset, active-low, asynchronous to clk.
- conflict_clr  in  CHANNELS  per-channel synchronous clear of the conflict flag, active-high.
- Q  out  CHANNELS  latch state.
- Qn  out  CHANNELS  always the bitwise complement of Q.
- conflict  out  CHANNELS  sticky flag; 1 means the channel has entered the both-asserted state.

## Operation
Per-channel registers:
- s1, s2: synchroniser, 2 bits each, holding the {Sn, Rn} pair.
- cand: candidate pair, 2 bits.
- cnt: counter, width clog2(DEBOUNCE+1).
- filt: filtered pair, 2 bits.
- fprev: previous filtered pair, 2 bits.
- Q.
- conflict.

Reset (async, while rst = 1):
- s1, s2, cand, filt and fprev = 2'b11 (inactive).
- cnt = DEBOUNCE (saturated).
- Q = RESET_Q, Qn = ~RESET_Q.
- conflict = 0.

Debounce, evaluated each edge:
- If s2 != cand: cand <= s2 and cnt <= 0.
- Else if cnt < DEBOUNCE: cnt <= cnt + 1, and filt <= cand on the edge where cnt reaches DEBOUNCE.
- Else: hold.
- Consequence: a change must be present in s2 for DEBOUNCE+1 consecutive samples to be accepted. Shorter pulses are discarded, and filt does not change.

Latch update, evaluated each edge from filt (s = ~filt[Sn], r = ~filt[Rn]):
- s & ~r: Q <= 1.
- ~s & r: Q <= 0.
- ~s & ~r: hold.
- s & r: resolved by CONFLICT_MODE:
  - 0: hold.
  - 1: Q <= 1.
  - 2: Q <= 0.
  - 3: Q <= ~Q only on the edge where fprev was not both-asserted; hold afterwards.
- fprev <= filt on every edge.

Conflict flag:
- It sets on the edge where filt is both-asserted and fprev is not.
- It clears on the edge where conflict_clr = 1.
- If a set and a clear fall on the same edge, the set wins.
- Leaving the both-asserted state does not clear it.

General:
- Channels are fully independent.
- Qn is combinational ~Q, so Q = Qn never occurs. This deliberately differs from NAND-latch behaviour.

## Timing
- Pin change to Q change: DEBOUNCE+4 rising edges, provided the pin is stable throughout (s1, s2, cand, DEBOUNCE counts to filt, then Q). With DEBOUNCE = 4 this is 8 edges.
- conflict asserts on the same edge as the corresponding Q update.
- conflict_clr takes effect on the next edge: 1-cycle latency.
- A bounce inside the window restarts the count from the edge where s2 differs.
- Reset asserted mid-count:
  - Outputs go to their reset values immediately.
  - Any pending change is discarded.
  - After release, a still-asserted input needs the full DEBOUNCE+4 edges.
- Direct set-to-reset transition at the pins (both change together): accepted as one pair change with no intermediate state.
- Staggered pins that pass through both-asserted for fewer than DEBOUNCE+1 samples produce no conflict.

## Test plan
All scenarios use CHANNELS = 4, DEBOUNCE = 4, RESET_Q = 0 unless noted.
- Reset, then Sn[0] = 0 from cycle 0 → Q[0] = 1 and Qn[0] = 0 exactly 8 edges later. Other channels stay at Q = 0 and conflict = 0.
- Rn[1] low pulse lasting 3 cycles while Q[1] = 1 → Q[1] stays 1. Repeat with a 6-cycle pulse → Q[1] = 0 at edge 8 after the falling edge.
- Sn[2] = Rn[2] = 0 held for 20 cycles, run once for each CONFLICT_MODE:
  - 0: Q holds.
  - 1: Q goes to 1.
  - 2: Q goes to 0.
  - 3: Q toggles exactly once.
  - In every mode, conflict[2] = 1 from edge 8 and stays 1 after release. Pulsing conflict_clr[2] clears it one edge later.
- Entry into conflict on the same edge as conflict_clr = 1 → conflict stays 1.
- rst asserted 5 cycles into a 8-cycle Sn[3] acceptance → Q[3] = 0 immediately. Sn still low after release → Q[3] = 1 at edge 8 after the release.
- RESET_Q = 1, CHANNELS = 1 → Q = 1 and Qn = 0 during and after reset with idle inputs.
